alu_dispatch_buffer: RTL

Two-wide in-order FIFO between rename/dispatch and the ALU issue unit. It absorbs back-pressure when the issue queue reports not-ready, so rename never has to stall mid-pair. It presents packed enqueue requests (lane 1 only with lane 0) to the issue queue's enq_req_0/1 and din_0/1. Payload is opaque; the issue queue computes scoreboard ready bits itself.

---
 rtl/alu_dispatch_buffer_if.sv | 40 ++++
 rtl/alu_dispatch_buffer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch_buffer_if.sv
// alu_dispatch_buffer_if
//   Handshake and payload bundle between rename/dispatch, the dispatch buffer
//   and the ALU issue queue.
//   master : the surrounding pipeline. It drives the rename lanes and the issue
//            queue ready. It observes in_ready, the enqueue requests and count.
//   slave  : the dispatch buffer itself.
//   Signals:
//     in_valid_0/1, in_data_0/1 : rename lanes (lane 1 younger)
//     in_ready                   : at least two free entries
//     iq_ready                   : issue queue can accept requests
//     out_req_0/1, out_data_0/1  : packed enqueue requests, oldest first
//     count                      : buffer occupancy
interface alu_dispatch_buffer_if #(
  parameter int DEPTH = 8,
  parameter int W     = 128
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid_0;
  logic             in_valid_1;
  logic [W-1:0]     in_data_0;
  logic [W-1:0]     in_data_1;
  logic             in_ready;
  logic             iq_ready;
  logic             out_req_0;
  logic             out_req_1;
  logic [W-1:0]     out_data_0;
  logic [W-1:0]     out_data_1;
  logic [CNT_W-1:0] count;

  modport master (
    output in_valid_0, in_valid_1, in_data_0, in_data_1, iq_ready,
    input  in_ready, out_req_0, out_req_1, out_data_0, out_data_1, count
  );

  modport slave (
    input  in_valid_0, in_valid_1, in_data_0, in_data_1, iq_ready,
    output in_ready, out_req_0, out_req_1, out_data_0, out_data_1, count
  );
endinterface

// File: rtl/alu_dispatch_buffer.sv
// alu_dispatch_buffer
//   Two-wide in-order FIFO between rename/dispatch and the ALU issue queue.
//   It absorbs issue-queue back-pressure so rename never stalls mid-pair.
//   The payload is opaque.
//   Ports:
//     clk, rst (synchronous, active-high), flush (discard everything)
//     bus : alu_dispatch_buffer_if.slave. It carries the rename lanes,
//           in_ready, iq_ready, the packed out_req_0/1 with out_data_0/1,
//           and count.
//   Build option:
//     ALU_DISP_BYPASS_EN : when defined, incoming uops may leave in the same
//       cycle they arrive, filling output lanes behind buffered entries.
//       When undefined, every uop passes through the array. The outputs then
//       depend only on registers, iq_ready and flush/rst.
module alu_dispatch_buffer #(
  parameter int DEPTH = 8,
  parameter int W     = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  alu_dispatch_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count_r;

  logic             kill;
  logic             in_ready_c;
  logic             accept;
  logic [1:0]       inc_n;
  logic [W-1:0]     c0_data;
  logic [W-1:0]     c1_data;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic             deq_ok;
  logic             req_0;
  logic             req_1;
  logic [1:0]       out_n;
  logic [1:0]       buf_n;
  logic [1:0]       byp_n;
  logic [1:0]       wr_n;
  logic [W-1:0]     wr_data_0;
  logic [W-1:0]     wr_data_1;
  logic [W-1:0]     out_data_0_c;
  logic [W-1:0]     out_data_1_c;

  // Reset and flush both empty the buffer and gate all traffic this cycle.
  assign kill       = rst | flush;
  // Only the count register decides in_ready. A same-cycle dequeue does not
  // raise it, which keeps the rename stall path short.
  assign in_ready_c = (count_r <= CNT_W'(DEPTH - 2));
  assign accept     = in_ready_c & ~kill;
  assign inc_n      = accept ? ({1'b0, bus.in_valid_0} + {1'b0, bus.in_valid_1}) : 2'd0;

  // Compact the valid lanes in age order. A lone lane 1 moves to slot 0.
  // c1 matters only when both lanes are valid.
  assign c0_data = bus.in_valid_0 ? bus.in_data_0 : bus.in_data_1;
  assign c1_data = bus.in_data_1;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign deq_ok  = bus.iq_ready & ~kill;

`ifdef ALU_DISP_BYPASS_EN
  logic avail_ge1;
  logic avail_ge2;

  // Available = buffered + incoming.
  assign avail_ge1 = (count_r != '0) | (inc_n != 2'd0);
  assign avail_ge2 = (count_r >= CNT_W'(2))
                   | ((count_r == CNT_W'(1)) & (inc_n != 2'd0))
                   | (inc_n == 2'd2);
  assign req_0 = deq_ok & avail_ge1;
  assign req_1 = deq_ok & avail_ge2;

  // Buffered entries always go out first. Incoming uops take whatever output
  // lanes are left.
  always_comb begin
    out_n = {1'b0, req_0} + {1'b0, req_1};
    buf_n = out_n;
    if (count_r == '0) begin
      buf_n = 2'd0;
    end else if ((count_r == CNT_W'(1)) && (out_n != 2'd0)) begin
      buf_n = 2'd1;
    end
    byp_n = out_n - buf_n;
  end

  always_comb begin
    out_data_0_c = mem[head];
    out_data_1_c = mem[head_p1];
    if (count_r == '0) begin
      out_data_0_c = c0_data;
      out_data_1_c = c1_data;
    end else if (count_r == CNT_W'(1)) begin
      out_data_1_c = c0_data;
    end
  end
`else
  assign req_0 = deq_ok & (count_r != '0);
  assign req_1 = deq_ok & (count_r >= CNT_W'(2));

  always_comb begin
    out_n = {1'b0, req_0} + {1'b0, req_1};
    buf_n = out_n;
    byp_n = 2'd0;
  end

  assign out_data_0_c = mem[head];
  assign out_data_1_c = mem[head_p1];
`endif

  // Incoming uops that bypassed are skipped. The rest are written at
  // tail and tail+1.
  always_comb begin
    wr_n      = inc_n - byp_n;
    wr_data_0 = (byp_n == 2'd0) ? c0_data : c1_data;
    wr_data_1 = c1_data;
  end

  // ---- state update: pointers and occupancy ----
  always_ff @(posedge clk) begin
    if (kill) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      head    <= head + PTR_W'(buf_n);
      tail    <= tail + PTR_W'(wr_n);
      count_r <= count_r + CNT_W'(wr_n) - CNT_W'(buf_n);
    end
  end

  // ---- storage array (contents survive reset) ----
  always_ff @(posedge clk) begin
    if (wr_n != 2'd0) begin
      mem[tail] <= wr_data_0;
    end
    if (wr_n == 2'd2) begin
      mem[tail_p1] <= wr_data_1;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_req_0  = req_0;
  assign bus.out_req_1  = req_1;
  assign bus.out_data_0 = out_data_0_c;
  assign bus.out_data_1 = out_data_1_c;
  assign bus.count      = count_r;

  // Structural invariants of the packed request interface and the counter.
  a_req_packed : assert property (@(posedge clk) bus.out_req_1 |-> bus.out_req_0);
  a_count_max  : assert property (@(posedge clk) disable iff (rst) count_r <= CNT_W'(DEPTH));

endmodule
